pipe_mips32: RTL and testbench

PIPE_MIPS32 -- requirements
Module: pipe_mips32

---
 rtl/pipe_mips32_pkg.sv | 38 +++
 rtl/pipe_mips32_alu.sv | 30 +++
 rtl/pipe_mips32.sv | 184 ++++++++++++++++++
 tb/tb_pipe_mips32.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_mips32_pkg.sv
// pipe_mips32_pkg
// Shared definitions for the 5-stage MIPS32-subset pipeline: opcode constants,
// the instruction-class enum and a decoder from opcode to class.
package pipe_mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP
  } instr_class_e;

  // Unknown opcodes fall into NOP so they never write anything.
  function automatic instr_class_e decode_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return NOP;
    endcase
  endfunction

endpackage

// File: rtl/pipe_mips32_alu.sv
// pipe_mips32_alu
// Combinational ALU. Loads and stores use the add path for address generation.
// Ports:
//   op_i : 6-bit opcode of the instruction in EX
//   a_i  : first operand (rs, after forwarding)
//   b_i  : second operand (rt or sign-extended immediate)
//   y_o  : 32-bit result, wraps on overflow
module pipe_mips32_alu
  import pipe_mips32_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: y_o = a_i + b_i;
      OP_SUB, OP_SUBI:               y_o = a_i - b_i;
      OP_AND:                        y_o = a_i & b_i;
      OP_OR:                         y_o = a_i | b_i;
      OP_SLT, OP_SLTI:               y_o = {31'd0, $signed(a_i) < $signed(b_i)};
      OP_MUL:                        y_o = a_i * b_i;
      default:                       y_o = '0;
    endcase
  end

endmodule

// File: rtl/pipe_mips32.sv
// pipe_mips32
// Five-stage in-order MIPS32-subset pipeline (IF, ID, EX, MEM, WB) with a
// unified word-addressed memory, EX-stage branch resolution and ALU/load
// result forwarding into EX.
// Ports:
//   clk : single clock, all state updates on the rising edge
//   rst : asynchronous active-high reset; clears PC, status and valid bits
// Reg and Mem are deliberately not reset so they can be preloaded.
module pipe_mips32
  import pipe_mips32_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input logic clk,
  input logic rst
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  // Word address wrapped onto the memory size.
  function automatic logic [AW-1:0] mem_idx(input logic [31:0] a);
    logic [31:0] m;
    m = a % 32'(MEM_WORDS);
    return m[AW-1:0];
  endfunction

  logic         halt_pend_q;
  logic         ifid_valid_q;
  logic [31:0]  ifid_ir_q, ifid_npc_q;
  logic         idex_valid_q;
  logic [5:0]   idex_op_q;
  instr_class_e idex_class_q;
  logic [4:0]   idex_rs_q, idex_rt_q, idex_dst_q;
  logic [31:0]  idex_a_q, idex_b_q, idex_imm_q, idex_npc_q;
  logic         exmem_valid_q;
  instr_class_e exmem_class_q;
  logic [4:0]   exmem_dst_q;
  logic [31:0]  exmem_res_q, exmem_b_q;
  logic         memwb_valid_q;
  instr_class_e memwb_class_q;
  logic [4:0]   memwb_dst_q;
  logic [31:0]  memwb_res_q;

  logic [31:0]  fetch_ir, pc_d;
  logic [5:0]   id_op;
  logic [4:0]   id_rs, id_rt, id_rd, id_dst;
  logic [31:0]  id_imm, id_a, id_b;
  instr_class_e id_class;
  logic         hlt_in_id, stop_fetch;
  logic [31:0]  ex_a, ex_b, ex_alu_b, ex_res, ex_target;
  logic         ex_taken;
  logic [AW-1:0] mem_addr;
  logic [31:0]  mem_rdata;
  logic         mem_we, wb_we;

  assign fetch_ir = Mem[mem_idx(PC)];

  // Decode. Only writing instructions carry a nonzero destination, so
  // "dst != 0" doubles as the register-write enable further down the pipe.
  assign id_op    = ifid_ir_q[31:26];
  assign id_rs    = ifid_ir_q[25:21];
  assign id_rt    = ifid_ir_q[20:16];
  assign id_rd    = ifid_ir_q[15:11];
  assign id_imm   = {{16{ifid_ir_q[15]}}, ifid_ir_q[15:0]};
  assign id_class = decode_class(id_op);
  assign id_dst   = (id_class == RR_ALU) ? id_rd :
                    (id_class == RM_ALU || id_class == LOAD) ? id_rt : 5'd0;

  // Register read with write-through from the instruction in WB.
  assign wb_we = memwb_valid_q && (memwb_dst_q != 5'd0) && !HALTED;
  assign id_a  = (id_rs == 5'd0) ? 32'd0 :
                 (wb_we && memwb_dst_q == id_rs) ? memwb_res_q : Reg[id_rs];
  assign id_b  = (id_rt == 5'd0) ? 32'd0 :
                 (wb_we && memwb_dst_q == id_rt) ? memwb_res_q : Reg[id_rt];

  // Forwarding into EX, youngest first. A load in EX/MEM has no data yet, so
  // only MEM/WB may supply a loaded value.
  assign ex_a = (idex_rs_q != 5'd0 && exmem_valid_q && exmem_class_q != LOAD &&
                 exmem_dst_q == idex_rs_q) ? exmem_res_q :
                (idex_rs_q != 5'd0 && memwb_valid_q &&
                 memwb_dst_q == idex_rs_q) ? memwb_res_q : idex_a_q;
  assign ex_b = (idex_rt_q != 5'd0 && exmem_valid_q && exmem_class_q != LOAD &&
                 exmem_dst_q == idex_rt_q) ? exmem_res_q :
                (idex_rt_q != 5'd0 && memwb_valid_q &&
                 memwb_dst_q == idex_rt_q) ? memwb_res_q : idex_b_q;

  assign ex_alu_b = (idex_class_q == RR_ALU) ? ex_b : idex_imm_q;

  pipe_mips32_alu u_alu (
    .op_i (idex_op_q),
    .a_i  (ex_a),
    .b_i  (ex_alu_b),
    .y_o  (ex_res)
  );

  assign ex_taken  = idex_valid_q && (idex_class_q == BRANCH) &&
                     ((idex_op_q == OP_BEQZ) ? (ex_a == 32'd0) : (ex_a != 32'd0));
  assign ex_target = idex_npc_q + idex_imm_q;

  assign mem_addr  = mem_idx(exmem_res_q);
  assign mem_rdata = Mem[mem_addr];
  assign mem_we    = exmem_valid_q && (exmem_class_q == STORE) && !HALTED;

  // A HLT in ID freezes fetch unless an older taken branch squashes it.
  assign hlt_in_id  = ifid_valid_q && (id_class == HALT);
  assign stop_fetch = halt_pend_q || hlt_in_id;
  assign pc_d = ex_taken ? ex_target : (stop_fetch ? PC : PC + 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC            <= '0;
      HALTED        <= 1'b0;
      TAKEN_BRANCH  <= 1'b0;
      halt_pend_q   <= 1'b0;
      ifid_valid_q  <= 1'b0;
      ifid_ir_q     <= '0;
      ifid_npc_q    <= '0;
      idex_valid_q  <= 1'b0;
      idex_op_q     <= '0;
      idex_class_q  <= NOP;
      idex_rs_q     <= '0;
      idex_rt_q     <= '0;
      idex_dst_q    <= '0;
      idex_a_q      <= '0;
      idex_b_q      <= '0;
      idex_imm_q    <= '0;
      idex_npc_q    <= '0;
      exmem_valid_q <= 1'b0;
      exmem_class_q <= NOP;
      exmem_dst_q   <= '0;
      exmem_res_q   <= '0;
      exmem_b_q     <= '0;
      memwb_valid_q <= 1'b0;
      memwb_class_q <= NOP;
      memwb_dst_q   <= '0;
      memwb_res_q   <= '0;
    end else if (!HALTED) begin
      PC           <= pc_d;
      TAKEN_BRANCH <= ex_taken;
      HALTED       <= memwb_valid_q && (memwb_class_q == HALT);
      halt_pend_q  <= halt_pend_q || (hlt_in_id && !ex_taken);

      ifid_valid_q <= !(ex_taken || stop_fetch);
      ifid_ir_q    <= fetch_ir;
      ifid_npc_q   <= PC + 32'd1;

      idex_valid_q <= ifid_valid_q && !ex_taken;
      idex_op_q    <= id_op;
      idex_class_q <= id_class;
      idex_rs_q    <= id_rs;
      idex_rt_q    <= id_rt;
      idex_dst_q   <= id_dst;
      idex_a_q     <= id_a;
      idex_b_q     <= id_b;
      idex_imm_q   <= id_imm;
      idex_npc_q   <= ifid_npc_q;

      exmem_valid_q <= idex_valid_q;
      exmem_class_q <= idex_class_q;
      exmem_dst_q   <= idex_dst_q;
      exmem_res_q   <= ex_res;
      exmem_b_q     <= ex_b;

      memwb_valid_q <= exmem_valid_q;
      memwb_class_q <= exmem_class_q;
      memwb_dst_q   <= exmem_dst_q;
      memwb_res_q   <= (exmem_class_q == LOAD) ? mem_rdata : exmem_res_q;
    end
  end

  // Architectural storage has no reset; reset stops writes by clearing the
  // valid bits that gate both enables.
  always @(posedge clk) begin
    if (wb_we) Reg[memwb_dst_q] <= memwb_res_q;
    if (mem_we) Mem[mem_addr] <= exmem_b_q;
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// tb_pipe_mips32
// Directed bench for pipe_mips32: four small programs with a table of
// expected final register/memory values, plus hand-written sequences for
// post-halt stability and a mid-program reset.
module tb_pipe_mips32;

  logic clk;
  logic rst;

  int testsRun = 0;
  int testsFailed = 0;

  pipe_mips32 #(.MEM_WORDS(1024)) dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          prog;
    bit          isMem;
    int          idx;
    logic [31:0] expected;
    string       name;
  } check_t;

  check_t      checks[$];
  logic [31:0] progs [0:3][0:11];
  int          expTaken [0:3];
  logic [31:0] memSnap [0:1023];
  logic [31:0] regSnap [0:31];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Hold reset, preload Reg[k]=k, clear Mem and place program p at address 0.
  task automatic loadProgram(input int p);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_pc", dut.PC, 32'd0);
    checkOutput("reset_halted", {31'd0, dut.HALTED}, 32'd0);
    checkOutput("reset_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
    for (int i = 0; i < 12; i++) dut.Mem[i] = progs[p][i];
    for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
    dut.Mem[120] = 32'd85;
    dut.Mem[50]  = 32'hdeadbeef;
  endtask

  task automatic runToHalt(input int budget, output int takenCycles);
    bit halted;
    takenCycles = 0;
    halted = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (dut.TAKEN_BRANCH) takenCycles++;
      if (dut.HALTED) begin
        halted = 1'b1;
        break;
      end
    end
    checkOutput("halted_in_budget", {31'd0, halted}, 32'd1);
  endtask

  task automatic applyStimulus(input int p, output int takenCycles);
    loadProgram(p);
    @(negedge clk);
    rst = 1'b0;
    runToHalt(80, takenCycles);
  endtask

  function automatic void addCheck(input int p, input bit m, input int idx,
                                   input logic [31:0] e, input string n);
    check_t c;
    c.prog = p; c.isMem = m; c.idx = idx; c.expected = e; c.name = n;
    checks.push_back(c);
  endfunction

  initial begin
    int taken;
    int diffs;
    rst = 1'b1;

    progs[0] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                 32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                 32'hfc000000, 32'h0, 32'h0, 32'h0};
    progs[1] = '{32'h28010005, 32'h00211000, 32'h00411800, 32'hfc000000,
                 32'h24010032, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    progs[2] = '{32'h28010078, 32'h20220000, 32'h0c631800, 32'h2842002d,
                 32'h24220001, 32'hfc000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    progs[3] = '{32'h28010000, 32'h38200002, 32'h28040007, 32'h28050008,
                 32'h28060009, 32'hfc000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    expTaken = '{0, 0, 0, 1};

    addCheck(0, 0, 0, 32'd0,  "p0_r0");
    addCheck(0, 0, 1, 32'd10, "p0_r1");
    addCheck(0, 0, 2, 32'd20, "p0_r2");
    addCheck(0, 0, 3, 32'd25, "p0_r3");
    addCheck(0, 0, 4, 32'd30, "p0_r4");
    addCheck(0, 0, 5, 32'd55, "p0_r5");
    addCheck(1, 0, 1, 32'd5,  "fwd_r1");
    addCheck(1, 0, 2, 32'd10, "fwd_r2");
    addCheck(1, 0, 3, 32'd15, "fwd_r3");
    addCheck(1, 1, 50, 32'hdeadbeef, "sw_after_hlt");
    addCheck(2, 0, 1, 32'd120, "ls_r1");
    addCheck(2, 0, 2, 32'd130, "ls_r2");
    addCheck(2, 1, 121, 32'd130, "ls_mem121");
    addCheck(2, 1, 120, 32'd85, "ls_mem120");
    addCheck(3, 0, 1, 32'd0, "br_r1");
    addCheck(3, 0, 4, 32'd4, "br_r4_squashed");
    addCheck(3, 0, 5, 32'd5, "br_r5_squashed");
    addCheck(3, 0, 6, 32'd9, "br_r6");

    for (int p = 0; p < 4; p++) begin
      applyStimulus(p, taken);
      checkOutput($sformatf("p%0d_taken_cycles", p), 32'(taken), 32'(expTaken[p]));
      foreach (checks[i]) begin
        if (checks[i].prog == p)
          checkOutput(checks[i].name,
                      checks[i].isMem ? dut.Mem[checks[i].idx] : dut.Reg[checks[i].idx],
                      checks[i].expected);
      end
    end

    // After halting, 20 more clocks must change nothing.
    applyStimulus(1, taken);
    for (int i = 0; i < 1024; i++) memSnap[i] = dut.Mem[i];
    for (int k = 0; k < 32; k++) regSnap[k] = dut.Reg[k];
    begin
      logic [31:0] pcSnap;
      pcSnap = dut.PC;
      repeat (20) @(negedge clk);
      checkOutput("halt_pc_stable", dut.PC, pcSnap);
    end
    checkOutput("halt_still_halted", {31'd0, dut.HALTED}, 32'd1);
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (dut.Mem[i] !== memSnap[i]) diffs++;
    for (int k = 0; k < 32; k++) if (dut.Reg[k] !== regSnap[k]) diffs++;
    checkOutput("halt_state_diffs", 32'(diffs), 32'd0);
    checkOutput("halt_mem50", dut.Mem[50], 32'hdeadbeef);

    // Mid-program reset: abort in-flight work, then rerun from address 0.
    loadProgram(0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_pc", dut.PC, 32'd0);
    checkOutput("midrst_halted", {31'd0, dut.HALTED}, 32'd0);
    dut.Reg[1] = 32'd99;
    @(negedge clk);
    checkOutput("midrst_no_write", dut.Reg[1], 32'd99);
    rst = 1'b0;
    runToHalt(80, taken);
    checkOutput("midrst_r1", dut.Reg[1], 32'd10);
    checkOutput("midrst_r2", dut.Reg[2], 32'd20);
    checkOutput("midrst_r3", dut.Reg[3], 32'd25);
    checkOutput("midrst_r4", dut.Reg[4], 32'd30);
    checkOutput("midrst_r5", dut.Reg[5], 32'd55);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
